// File: rtl/assign_ex_checker.sv
// assign_ex_checker: scores the four assignment-variant outputs z1..z4 against
// golden timing models over a fixed-length run and reports per-channel errors.
module assign_ex_checker #(
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         a,
  input  logic [3:0]         z,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [4*CNT_W-1:0] err_cnt,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic [1:0]         first_err_ch,
  output logic               err_seen
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         a_d1;
  logic [3:0]         a_d2;
  logic [3:0]         expect_z;
  logic [3:0]         active;
  logic [3:0]         mismatch;
  logic [4*CNT_W-1:0] cnt_next;
  logic [1:0]         low_ch;

  function automatic logic g_of(input logic [3:0] v);
    return (v[0] | ~v[1]) & (v[2] | v[3]);
  endfunction

  // Golden values per variant; the clocked variants lag the stimulus and are
  // masked until their history registers hold real run data.
  always_comb begin
    expect_z[0] = g_of(a) ^ a[0];
    expect_z[1] = g_of(a) ^ a[0];
    expect_z[2] = g_of(a_d1) ^ a_d1[0];
    expect_z[3] = g_of(a_d2) ^ a_d1[0];
    active      = {idx >= IDX_W'(2), idx >= IDX_W'(1), 2'b11};
    mismatch    = '0;
    cnt_next    = err_cnt;
    low_ch      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      mismatch[k] = active[k] & (z[k] !== expect_z[k]);
      if (mismatch[k] && err_cnt[k*CNT_W +: CNT_W] != CNT_MAX)
        cnt_next[k*CNT_W +: CNT_W] = err_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
    for (int k = 3; k >= 0; k--) begin
      if (mismatch[k])
        low_ch = 2'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d1 <= '0;
      a_d2 <= '0;
    end else begin
      a_d1 <= a;
      a_d2 <= a_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_ch  <= 2'd0;
      err_seen      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            idx           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_ch  <= 2'd0;
            err_seen      <= 1'b0;
          end
        end
        RUN: begin
          err_cnt <= cnt_next;
          if ((|mismatch) && !err_seen) begin
            err_seen      <= 1'b1;
            first_err_idx <= idx;
            first_err_ch  <= low_ch;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (cnt_next == '0);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assign_ex_checker.sv
// tb_assign_ex_checker: drives directed and randomized runs into two checker
// instances (8-bit and 2-bit counters) and compares against a sequence model.
module tb_assign_ex_checker;

  localparam int NV  = 16;
  localparam int CW  = 8;
  localparam int CW2 = 2;
  localparam int IW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    a;
  logic [3:0]    z;
  logic          busy, done, pass, err_seen;
  logic [4*CW-1:0] err_cnt;
  logic [IW-1:0] first_err_idx;
  logic [1:0]    first_err_ch;
  logic          busy2, done2, pass2, err_seen2;
  logic [4*CW2-1:0] err_cnt2;
  logic [IW-1:0] first_err_idx2;
  logic [1:0]    first_err_ch2;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] aSeq [NV];
  logic [3:0] zSeq [NV];
  int         expCnt [4];
  int         expFirstIdx;
  int         expFirstCh;
  logic       expSeen;

  assign_ex_checker #(.NUM_VECTORS(NV), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .z(z),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_ch(first_err_ch), .err_seen(err_seen)
  );

  assign_ex_checker #(.NUM_VECTORS(NV), .CNT_W(CW2), .IDX_W(IW)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a(a), .z(z),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_err_idx(first_err_idx2), .first_err_ch(first_err_ch2), .err_seen(err_seen2)
  );

  always #5 clk = ~clk;

  function automatic logic gRef(input logic [3:0] v);
    return (v[0] | ~v[1]) & (v[2] | v[3]);
  endfunction

  function automatic logic fRef(input logic [3:0] v);
    return gRef(v) ^ v[0];
  endfunction

  function automatic bit isMasked(input int i, input int ch);
    return (ch == 2 && i < 1) || (ch == 3 && i < 2);
  endfunction

  // What a correct z-channel shows at sample i, from the stimulus sequence alone.
  function automatic logic refBit(input int i, input int ch);
    case (ch)
      0, 1:    return fRef(aSeq[i]);
      2:       return fRef(aSeq[i-1]);
      default: return gRef(aSeq[i-2]) ^ aSeq[i-1][0];
    endcase
  endfunction

  task automatic fillGood();
    for (int i = 0; i < NV; i++)
      for (int ch = 0; ch < 4; ch++)
        zSeq[i][ch] = isMasked(i, ch) ? 1'($urandom) : refBit(i, ch);
  endtask

  task automatic runModel();
    expSeen = 1'b0;
    expFirstIdx = 0;
    expFirstCh = 0;
    for (int ch = 0; ch < 4; ch++) expCnt[ch] = 0;
    for (int i = 0; i < NV; i++)
      for (int ch = 0; ch < 4; ch++)
        if (!isMasked(i, ch) && (zSeq[i][ch] !== refBit(i, ch))) begin
          expCnt[ch]++;
          if (!expSeen) begin
            expSeen = 1'b1;
            expFirstIdx = i;
            expFirstCh = ch;
          end
        end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full run: start pulse, then one stimulus vector per cycle.
  task automatic applyStimulus(input bit midStart);
    @(negedge clk);
    start = 1'b1;
    a = 4'($urandom);
    z = 4'($urandom);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      a = aSeq[i];
      z = zSeq[i];
      start = (midStart && i == 5);
      if (i == 0 || i == 9) begin
        checkOutput($sformatf("busy_i%0d", i), busy, 1);
        checkOutput($sformatf("done_i%0d", i), done, 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic checkResults(input string name);
    int allZero;
    allZero = 1;
    runModel();
    checkOutput({name, "_done"}, done, 1);
    checkOutput({name, "_busy"}, busy, 0);
    for (int ch = 0; ch < 4; ch++) begin
      if (expCnt[ch] != 0) allZero = 0;
      checkOutput($sformatf("%s_cnt%0d", name, ch), err_cnt[ch*CW +: CW],
                  (expCnt[ch] > 255) ? 255 : expCnt[ch]);
      checkOutput($sformatf("%s_sat%0d", name, ch), err_cnt2[ch*CW2 +: CW2],
                  (expCnt[ch] > 3) ? 3 : expCnt[ch]);
    end
    checkOutput({name, "_pass"}, pass, allZero);
    checkOutput({name, "_pass2"}, pass2, allZero);
    checkOutput({name, "_seen"}, err_seen, expSeen);
    checkOutput({name, "_fidx"}, first_err_idx, expFirstIdx);
    checkOutput({name, "_fch"}, first_err_ch, expFirstCh);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    z = 4'd0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_seen", err_seen, 0);
    checkOutput("rst_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] counting stimulus, correct outputs");
    for (int i = 0; i < NV; i++) aSeq[i] = 4'(i);
    fillGood();
    applyStimulus(0);
    checkResults("good");
    repeat (3) @(negedge clk);
    checkOutput("hold_done", done, 1);
    checkOutput("hold_pass", pass, 1);

    $display("[TB] z1 stuck low");
    fillGood();
    for (int i = 0; i < NV; i++) zSeq[i][0] = 1'b0;
    applyStimulus(0);
    checkResults("z1low");

    $display("[TB] z2 inverted, saturation");
    fillGood();
    for (int i = 0; i < NV; i++) zSeq[i][1] = ~zSeq[i][1];
    applyStimulus(0);
    checkResults("z2inv");

    $display("[TB] z4 wrong only in warm-up");
    fillGood();
    zSeq[0][3] = ~refBit(2, 3);
    zSeq[1][3] = ~zSeq[0][3];
    applyStimulus(0);
    checkResults("warmup");

    $display("[TB] z3 and z4 wrong at index 5, start pulse mid-run");
    fillGood();
    zSeq[5][2] = ~zSeq[5][2];
    zSeq[5][3] = ~zSeq[5][3];
    applyStimulus(1);
    checkResults("dual5");

    $display("[TB] unknown z1 at index 3");
    fillGood();
    zSeq[3][0] = 1'bx;
    applyStimulus(0);
    checkResults("xz1");

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NV; i++) aSeq[i] = 4'($urandom);
      fillGood();
      for (int i = 0; i < NV; i++)
        for (int ch = 0; ch < 4; ch++)
          if ($urandom_range(7) == 0) zSeq[i][ch] = ~zSeq[i][ch];
      applyStimulus(r == 2);
      checkResults($sformatf("rand%0d", r));
    end

    $display("[TB] reset mid-run");
    for (int i = 0; i < NV; i++) begin
      aSeq[i] = 4'($urandom);
      zSeq[i] = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = ~aSeq[i];
      z = zSeq[i];
      if (i < 7) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_done", done, 0);
    checkOutput("mrst_seen", err_seen, 0);
    checkOutput("mrst_cnt", err_cnt, 0);
    checkOutput("mrst_fidx", first_err_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    fillGood();
    applyStimulus(0);
    checkResults("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/assign_ex_checker.md
Name: assign_ex_checker

Overview:
- Downstream consumer of the four-variant assignment demo top, which exposes z1..z4.
- Samples the stimulus vector and the four z outputs every clock during a run.
- Computes a golden result for each variant's timing model and counts mismatches per channel.
- Reports pass/fail plus the first failure's location, so lab benches are self-checking instead of waveform-inspected.

Parameters:
NUM_VECTORS, 16, samples taken per run (>=3).
CNT_W, 8, width of each per-channel mismatch counter (saturating).
IDX_W, 8, width of the sample index and first_err_idx (must hold NUM_VECTORS-1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begins a run; honoured in IDLE or DONE only.
a  in  4  stimulus currently applied to the DUT; a[0]=a0 .. a[3]=a3.
z  in  4  DUT outputs; z[0]=z1, z[1]=z2, z[2]=z3, z[3]=z4.
busy  out  1  high while in RUN.
done  out  1  high while in DONE.
pass  out  1  done and all four counters zero.
err_cnt  out  4*CNT_W  channel k counter in bits [k*CNT_W +: CNT_W].
first_err_idx  out  IDX_W  sample index of the first mismatch in the run.
first_err_ch  out  2  lowest-numbered mismatching channel at that index.
err_seen  out  1  at least one mismatch in the current or last run.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state=IDLE; busy, done, pass, err_seen = 0.
  - err_cnt, first_err_idx, first_err_ch = 0.
  - idx, a_d1, a_d2 = 0.
  - Reset mid-run aborts the run immediately; no partial result is retained.
- Golden functions: g(a) = (a0 | ~a1) & (a2 | a3); f(a) = g(a) ^ a0.
- History registers: a_d1 <= a and a_d2 <= a_d1 on every clock in every state, so they track the DUT's free-running flops.
- Expected value at sample edge with index i:
  - ch0, ch1 (continuous and comb): f(a) of the current cycle; compared from i>=0.
  - ch2 (clocked, blocking): f(a_d1); compared from i>=1.
  - ch3 (clocked, non-blocking): g(a_d2) ^ a_d1[0]; compared from i>=2.
  - Comparisons below a channel's start index are masked, which removes warm-up ambiguity.
- FSM:
  - IDLE: on start, go to RUN. On entry, idx=0 and counters, first_err_*, err_seen are cleared. The first sample is taken at the next rising edge.
  - RUN: each edge samples index idx; mismatching channels' counters increment, saturating at 2^CNT_W-1. If idx==NUM_VECTORS-1, go to DONE; otherwise idx++. start is ignored.
  - DONE: results are held. On start, go to RUN with the same clearing as IDLE->RUN.
- Mismatch capture: on the first edge with any unmasked mismatch while err_seen=0:
  - err_seen <= 1; first_err_idx <= idx; first_err_ch <= lowest mismatching channel.
  - Simultaneous mismatches all increment their own counters; only the lowest channel is reported.
- Output timing:
  - busy=1 from the cycle after start is accepted through the cycle of the last sample edge.
  - done=1 the cycle after the last sample.
  - pass is registered: pass=1 iff done and all counters are 0. Saturated counters never report 0.
- Invalid or unknown z is counted as a mismatch; inequality uses !==.

Test Plan:
- Correct DUT, NUM_VECTORS=16, a = 0,1,..,15 one per cycle from the first sample -> done after 16 samples, pass=1, err_cnt all 0, err_seen=0.
- Same stimulus, z[0] forced 0 -> err_cnt ch0=5 (f=1 at a=1,3,4,8,12), other channels 0, first_err_idx=1, first_err_ch=0, pass=0.
- CNT_W=2, z[1] inverted for the whole run -> err_cnt ch1=3 (saturated), pass=0.
- z[3] forced wrong only at indices 0 and 1, correct afterwards -> no errors (warm-up mask), pass=1.
- z[2] and z[3] both wrong at index 5 only -> both counters=1, first_err_idx=5, first_err_ch=2.
- Reset and start behaviour:
  - Assert rst at index 7 -> outputs return to reset values in the same cycle; state=IDLE.
  - Start pulse during RUN -> ignored.
  - Start in DONE -> counters cleared, new run completes normally.
